// File: rtl/approx_err_monitor.sv
// +----------------------------------------------------------------------------+
// | approx_err_monitor                                                         |
// | Accumulates error metrics of an approximate adder against its exact sum.   |
// | Optional: ERRMON_WORST_CAPTURE_EN adds worst-case operand capture ports.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module approx_err_monitor #(
  parameter int N     = 16,
  parameter int K     = 11,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
`ifdef ERRMON_WORST_CAPTURE_EN
  output logic [N-1:0]     worst_a,
  output logic [N-1:0]     worst_b,
  output logic [N-1:0]     worst_approx,
`endif
  output logic [N-1:0]     max_ed
);

  // K describes the upstream adder only; reject impossible configurations.
  generate
    if (K < 1 || K > N) begin : g_k_range_bad
      $error("approx_err_monitor: K must satisfy 0 < K <= N");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_accepted;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;

  logic             r_s1_valid;
  logic [N-1:0]     r_s1_ed;

  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_err_count;
  logic [ACC_W-1:0] r_sum_ed;
  logic [N-1:0]     r_max_ed;

`ifdef ERRMON_WORST_CAPTURE_EN
  logic [N-1:0]     r_s1_a;
  logic [N-1:0]     r_s1_b;
  logic [N-1:0]     r_s1_approx;
  logic [N-1:0]     r_worst_a;
  logic [N-1:0]     r_worst_b;
  logic [N-1:0]     r_worst_approx;
`endif

  logic [N-1:0]     w_exact;
  logic [N-1:0]     w_ed;
  logic             w_xfer;
  logic             w_last;
  logic             w_start_ok;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_sum_sat;

  // Carry-out is dropped so the reference matches the adder's N-bit sum port.
  assign w_exact    = a + b;
  assign w_ed       = (w_exact >= approx_sum) ? (w_exact - approx_sum)
                                              : (approx_sum - w_exact);
  assign w_xfer     = in_valid & r_in_ready;
  assign w_last     = ((r_accepted + CNT_W'(1)) == r_target);
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  assign w_sum_ext  = {1'b0, r_sum_ed} + {{(ACC_W + 1 - N){1'b0}}, r_s1_ed};
  assign w_sum_sat  = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_target       <= '0;
      r_accepted     <= '0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_s1_ed        <= '0;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_sum_ed       <= '0;
      r_max_ed       <= '0;
`ifdef ERRMON_WORST_CAPTURE_EN
      r_s1_a         <= '0;
      r_s1_b         <= '0;
      r_s1_approx    <= '0;
      r_worst_a      <= '0;
      r_worst_b      <= '0;
      r_worst_approx <= '0;
`endif
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_ed     <= w_ed;
`ifdef ERRMON_WORST_CAPTURE_EN
        r_s1_a      <= a;
        r_s1_b      <= b;
        r_s1_approx <= approx_sum;
`endif
      end

      if (r_s1_valid) begin
        r_sample_count <= r_sample_count + CNT_W'(1);
        if (r_s1_ed != '0) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        r_sum_ed <= w_sum_sat;
        if (r_s1_ed > r_max_ed) begin
          r_max_ed       <= r_s1_ed;
`ifdef ERRMON_WORST_CAPTURE_EN
          r_worst_a      <= r_s1_a;
          r_worst_b      <= r_s1_b;
          r_worst_approx <= r_s1_approx;
`endif
        end
      end

      // Start clears follow the accumulate block so they win; the pipeline
      // is always empty in IDLE/DONE, so the two never collide in practice.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_target       <= n_samples;
            r_accepted     <= '0;
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sum_ed       <= '0;
            r_max_ed       <= '0;
`ifdef ERRMON_WORST_CAPTURE_EN
            r_worst_a      <= '0;
            r_worst_b      <= '0;
            r_worst_approx <= '0;
`endif
            if (n_samples == '0) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_accepted <= r_accepted + CNT_W'(1);
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!r_s1_valid) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_count = r_sample_count;
  assign err_count    = r_err_count;
  assign sum_ed       = r_sum_ed;
  assign max_ed       = r_max_ed;
`ifdef ERRMON_WORST_CAPTURE_EN
  assign worst_a      = r_worst_a;
  assign worst_b      = r_worst_b;
  assign worst_approx = r_worst_approx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_approx_err_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_approx_err_monitor                                                      |
// | Self-checking bench: hand vectors, corner sequences, randomized runs.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_approx_err_monitor;
  localparam int N     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a, b, approx_sum;
  logic             busy, done;
  logic [CNT_W-1:0] sample_count, err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [N-1:0]     max_ed;
`ifdef ERRMON_WORST_CAPTURE_EN
  logic [N-1:0]     worst_a, worst_b, worst_approx;
`endif

  approx_err_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_samples    (n_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .approx_sum   (approx_sum),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .sum_ed       (sum_ed),
`ifdef ERRMON_WORST_CAPTURE_EN
    .worst_a      (worst_a),
    .worst_b      (worst_b),
    .worst_approx (worst_approx),
`endif
    .max_ed       (max_ed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] qa[$], qb[$], qp[$];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] p;
    int           ed;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_sample(input logic [N-1:0] sa, input logic [N-1:0] sb, input logic [N-1:0] sp);
    qa.push_back(sa);
    qb.push_back(sb);
    qp.push_back(sp);
  endtask

  task automatic clear_samples();
    qa.delete();
    qb.delete();
    qp.delete();
  endtask

  // Reference: metrics straight from the definitions over the sample list.
  task automatic model(output longint cnt, output longint errc, output longint sum,
                       output longint mx, output longint wa, output longint wb,
                       output longint wp);
    longint sat_max;
    sat_max = (longint'(1) <<< ACC_W) - 1;
    cnt = 0; errc = 0; sum = 0; mx = 0; wa = 0; wb = 0; wp = 0;
    foreach (qa[i]) begin
      longint exact, ap, ed;
      exact = (longint'(qa[i]) + longint'(qb[i])) % (longint'(1) <<< N);
      ap    = longint'(qp[i]);
      ed    = (exact > ap) ? exact - ap : ap - exact;
      cnt++;
      if (ed != 0) errc++;
      sum = sum + ed;
      if (sum > sat_max) sum = sat_max;
      if (ed > mx) begin
        mx = ed; wa = longint'(qa[i]); wb = longint'(qb[i]); wp = ap;
      end
    end
  endtask

  task automatic check_results(input string tag);
    longint cnt, errc, sum, mx, wa, wb, wp;
    model(cnt, errc, sum, mx, wa, wb, wp);
    chk({tag, " sample_count"}, 64'(sample_count), cnt);
    chk({tag, " err_count"}, 64'(err_count), errc);
    chk({tag, " sum_ed"}, 64'(sum_ed), sum);
    chk({tag, " max_ed"}, 64'(max_ed), mx);
`ifdef ERRMON_WORST_CAPTURE_EN
    chk({tag, " worst_a"}, 64'(worst_a), wa);
    chk({tag, " worst_b"}, 64'(worst_b), wb);
    chk({tag, " worst_approx"}, 64'(worst_approx), wp);
`endif
  endtask

  // Runs the queued samples; mid_start >= 0 pulses start (with a bogus count) mid-run.
  task automatic run(input int n, input bit gaps, input int mid_start, input string tag);
    int idx, xf, cyc;
    @(negedge clk);
    n_samples = CNT_W'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) begin
      chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
      chk({tag, " done_dropped"}, 64'(done), 64'd0);
    end
    idx = 0; xf = 0; cyc = 0;
    while (!done && cyc < 5000) begin
      if (cyc == mid_start) begin
        start = 1'b1;
        n_samples = CNT_W'(n + 5);
      end else begin
        start = 1'b0;
      end
      if (idx < n && (!gaps || $urandom_range(2) != 0)) begin
        in_valid = 1'b1; a = qa[idx]; b = qb[idx]; approx_sum = qp[idx];
      end else begin
        in_valid = (idx >= n);
        a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
      end
      if (in_valid && in_ready) begin
        xf++; idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, " done_reached"}, 64'(done), 64'd1);
    chk({tag, " transfers"}, 64'(xf), 64'(n));
    chk({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    check_results(tag);
    repeat (3) @(negedge clk);
    chk({tag, " done_held"}, 64'(done), 64'd1);
    check_results({tag, " held"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{16'h1234, 16'h5678, 16'h68AC, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000, 0};
    tbl[2] = '{16'hAAAA, 16'h5555, 16'hFFF0, 15};
    tbl[3] = '{16'h0100, 16'h0010, 16'h011C, 12};
    tbl[4] = '{16'h0000, 16'h0000, 16'hFFFF, 65535};
    tbl[5] = '{16'h8000, 16'h8000, 16'h0001, 1};
    tbl[6] = '{16'h1000, 16'h0234, 16'h0234, 4096};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = '0;
    a = '0; b = '0; approx_sum = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset sample_count", 64'(sample_count), 64'd0);
    chk("reset err_count", 64'(err_count), 64'd0);
    chk("reset sum_ed", 64'(sum_ed), 64'd0);
    chk("reset max_ed", 64'(max_ed), 64'd0);

    // Single exact sample, checking the two-cycle result latency and done timing.
    n_samples = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("single in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = 16'h1234; b = 16'h5678; approx_sum = 16'h68AC;
    @(negedge clk);
    in_valid = 1'b0;
    chk("single in_ready_low", 64'(in_ready), 64'd0);
    chk("single count_not_yet", 64'(sample_count), 64'd0);
    chk("single busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("single count_visible", 64'(sample_count), 64'd1);
    chk("single done_not_yet", 64'(done), 64'd0);
    @(negedge clk);
    chk("single done", 64'(done), 64'd1);
    chk("single err_count", 64'(err_count), 64'd0);
    chk("single sum_ed", 64'(sum_ed), 64'd0);
    chk("single max_ed", 64'(max_ed), 64'd0);

    // Hand vector table, one sample per run.
    for (int i = 0; i < 8; i++) begin
      clear_samples();
      add_sample(tbl[i].a, tbl[i].b, tbl[i].p);
      run(1, 1'b0, -1, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d ed", i), 64'(max_ed), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d sum", i), 64'(sum_ed), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d err", i), 64'(err_count), 64'(tbl[i].ed != 0));
    end

    // Wrap pair.
    clear_samples();
    add_sample(16'hFFFF, 16'h0001, 16'h0000);
    add_sample(16'hAAAA, 16'h5555, 16'hFFF0);
    run(2, 1'b0, -1, "wrap");
    chk("wrap err_count", 64'(err_count), 64'd1);
    chk("wrap sum_ed", 64'(sum_ed), 64'd15);
    chk("wrap max_ed", 64'(max_ed), 64'd15);

    // ED 12, 0, 12 with gaps; tie keeps the first worst sample.
    clear_samples();
    add_sample(16'h0100, 16'h0010, 16'h011C);
    add_sample(16'h0001, 16'h0002, 16'h0003);
    add_sample(16'h2000, 16'h0001, 16'h1FF5);
    run(3, 1'b1, -1, "gaps");
    chk("gaps err_count", 64'(err_count), 64'd2);
    chk("gaps sum_ed", 64'(sum_ed), 64'd24);
    chk("gaps max_ed", 64'(max_ed), 64'd12);
`ifdef ERRMON_WORST_CAPTURE_EN
    chk("gaps worst_a_first", 64'(worst_a), 64'h0100);
    chk("gaps worst_b_first", 64'(worst_b), 64'h0010);
    chk("gaps worst_approx_first", 64'(worst_approx), 64'h011C);
`endif

    // Zero-sample run.
    clear_samples();
    run(0, 1'b0, -1, "zero");
    chk("zero sample_count", 64'(sample_count), 64'd0);

    // Reset after 2 of 4 transfers.
    @(negedge clk);
    n_samples = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; a = 16'h0000; b = 16'h0000; approx_sum = 16'h0005;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; approx_sum = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd0);
    chk("abort sample_count", 64'(sample_count), 64'd0);
    chk("abort sum_ed", 64'(sum_ed), 64'd0);
    chk("abort max_ed", 64'(max_ed), 64'd0);
    @(negedge clk);
    chk("abort no_late_accum", 64'(sample_count), 64'd0);
    clear_samples();
    for (int i = 0; i < 4; i++) add_sample(N'(i * 7), N'(i * 3), N'(i * 11));
    run(4, 1'b0, -1, "after_abort");

    // Start pulsed mid-run must be ignored.
    clear_samples();
    for (int i = 0; i < 6; i++) add_sample(N'($urandom), N'($urandom), N'($urandom));
    run(6, 1'b0, 2, "mid_start");

    // Randomized runs, each started from DONE.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 12);
      clear_samples();
      for (int i = 0; i < n; i++) begin
        logic [N-1:0] ra, rb, rex, rp;
        ra = N'($urandom); rb = N'($urandom); rex = ra + rb;
        case ($urandom_range(3))
          0:       rp = rex;
          1:       rp = rex ^ N'($urandom_range(255));
          2:       rp = N'($urandom);
          default: rp = rex + N'($urandom_range(15));
        endcase
        add_sample(ra, rb, rp);
      end
      run(n, r[0], -1, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Response-side companion to the approximate-adder stimulus benches: consumes (A, B, approximate sum) triples and accumulates error metrics against the exact sum.
- Sits downstream of any N-bit approximate adder, e.g. the K-bit approximate-segment adders in the Design tree.
- Reports error count, sum of error distances and max error distance over a programmed sample count.
- Used in simulation and on-chip characterisation wrappers.

Parameters:
- N, 16, operand/sum width (matches adder n).
- K, 11, approximate-segment width; informational only; must satisfy 0 < K <= N.
- CNT_W, 32, width of sample counters.
- ACC_W, 48, width of sum-of-error-distance accumulator.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run; sampled only in IDLE or DONE
- n_samples  in  CNT_W  samples per run; latched on accepted start
- in_valid  in  1  sample present
- in_ready  out  1  monitor accepts sample
- a  in  N  operand A
- b  in  N  operand B
- approx_sum  in  N  adder output for (a, b)
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE until next start or rst
- sample_count  out  CNT_W  samples accumulated
- err_count  out  CNT_W  samples with ED != 0
- sum_ed  out  ACC_W  sum of error distances
- max_ed  out  N  largest error distance

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on rising clk. rst has priority over every other input.
- Reset values: in_ready=0, busy=0, done=0, all counters, accumulators and max_ed = 0, state=IDLE.
- Exact sum: (a+b) mod 2^N; carry-out discarded, matching the adder's N-bit sum port.
- Error distance: ED = |exact - approx_sum|, both treated as N-bit unsigned. Result is N bits.
- States:
  - IDLE: start=1 latches n_samples, clears all results, goes to RUN. If n_samples=0, goes straight to DONE with all results 0.
  - RUN: in_ready=1 while accepted < n_samples. Transfer = in_valid & in_ready. After the n_samples-th transfer, in_ready=0 next cycle and state goes to DRAIN.
  - DRAIN: waits until the pipeline is empty, then goes to DONE.
  - DONE: done=1; results held stable. start=1 re-enters as in IDLE: results clear, done drops next cycle.
- start during RUN or DRAIN is ignored.
- Pipeline, 2 stages:
  - Stage 1 registers exact sum and ED with a valid bit.
  - Stage 2 updates the accumulators.
  - Outputs reflect a sample 2 cycles after its transfer.
  - done rises no earlier than the cycle after the final accumulation is visible.
- Accumulation per valid stage-2 sample:
  - sample_count += 1.
  - err_count += 1 if ED != 0.
  - sum_ed += ED; saturates at all-ones, never wraps.
  - max_ed = ED if ED > max_ed. Ties keep the existing value.
- in_valid is ignored when in_ready=0. a, b and approx_sum need only be stable in the transfer cycle.
- rst mid-run aborts immediately: next cycle all outputs are at reset values, including a partially filled pipeline.

Optional Feature:
- Macro ERRMON_WORST_CAPTURE_EN.
- Defined:
  - Adds outputs worst_a (N), worst_b (N), worst_approx (N); reset 0, cleared on start.
  - Loaded from the stage-2 sample whenever max_ed updates (strictly greater).
  - Otherwise held; stable in DONE.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Single exact sample: start, n_samples=1, a=16'h1234, b=16'h5678, approx_sum=16'h68AC -> done; sample_count=1, err_count=0, sum_ed=0, max_ed=0.
- Wrap case: a=16'hFFFF, b=16'h0001, approx_sum=16'h0000 -> ED=0. Then a=16'hAAAA, b=16'h5555, approx_sum=16'hFFF0 -> ED=15. With n_samples=2: err_count=1, sum_ed=15, max_ed=15.
- Multi-sample with in_valid gaps, n_samples=3, ED sequence 12, 0, 12:
  - err_count=2, sum_ed=24, max_ed=12.
  - With ERRMON_WORST_CAPTURE_EN: worst_* equal the first ED=12 sample (tie kept).
  - in_ready=0 after the third transfer; extra in_valid pulses are not counted.
- n_samples=0 start -> DONE the next cycle, all results 0, in_ready never asserted.
- rst asserted after 2 of 4 transfers -> next cycle busy=0, done=0, all counters 0, state IDLE. A later start runs cleanly.
- start pulsed during RUN -> ignored; results match an uninterrupted run. start in DONE -> results clear and a new run begins.
